// File: rtl/mix_scheduler_pkg.sv
// Shared definitions for the time-multiplexed voice mixer: default sizing,
// sequencer state encoding and the output saturation limits.
package mix_defs;

  localparam int NUM_CH_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int GAIN_SHIFT_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_SCALE  = 2'd2,
    S_OUTPUT = 2'd3
  } mix_state_e;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int SAT_MAX = sat_hi(DATA_W_DEF);
  localparam int SAT_MIN = sat_lo(DATA_W_DEF);

endpackage

// File: rtl/mix_scheduler_sat_shift.sv
// Gain stage: arithmetic right shift of the wide accumulator, then clamp to
// the signed output range. Purely combinational.
module sat_shift
  import mix_defs::*;
#(
  parameter int ACC_W      = DATA_W_DEF + 3,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  parameter int SAT_HI     = SAT_MAX,
  parameter int SAT_LO     = SAT_MIN
) (
  input  logic signed [ACC_W-1:0]  acc_in,
  output logic signed [DATA_W-1:0] sat_out
);

  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(SAT_HI);
  localparam logic signed [ACC_W-1:0] LIM_LO = ACC_W'(SAT_LO);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc_in >>> GAIN_SHIFT;
    if (shifted > LIM_HI) begin
      sat_out = DATA_W'(SAT_HI);
    end else if (shifted < LIM_LO) begin
      sat_out = DATA_W'(SAT_LO);
    end else begin
      sat_out = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// Per-sample-period mix sequencer: walks the voice channels one per cycle
// through a shared accumulator, scales/saturates, and hands off one frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for sample_tick
// S_SCAN   | visiting channel idx, accumulating enabled+valid samples
// S_SCALE  | shift and saturate the sum into mix_out
// S_OUTPUT | frame presented, waiting for mix_ready
module mix_scheduler
  import mix_defs::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     sample_tick,
  input  logic [NUM_CH-1:0]        chan_enable,
  input  logic [NUM_CH-1:0]        chan_valid,
  input  logic [NUM_CH*DATA_W-1:0] chan_data,
  output logic [NUM_CH-1:0]        chan_ack,
  output logic [DATA_W-1:0]        mix_out,
  output logic                     mix_valid,
  input  logic                     mix_ready,
  output logic                     busy,
  output logic                     overrun,
  output logic                     underrun
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int ACC_W = DATA_W + $clog2(NUM_CH);

  mix_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;

  logic [DATA_W-1:0]        cur_sample;
  logic signed [ACC_W-1:0]  cur_sext;
  logic signed [DATA_W-1:0] sat_val;
  logic                     last_ch;

  assign cur_sample = chan_data[int'(idx_q)*DATA_W +: DATA_W];
  assign cur_sext   = {{(ACC_W-DATA_W){cur_sample[DATA_W-1]}}, cur_sample};
  assign last_ch    = (idx_q == IDX_W'(NUM_CH - 1));

  sat_shift #(
    .ACC_W      (ACC_W),
    .DATA_W     (DATA_W),
    .GAIN_SHIFT (GAIN_SHIFT),
    .SAT_HI     (sat_hi(DATA_W)),
    .SAT_LO     (sat_lo(DATA_W))
  ) u_sat (
    .acc_in  (acc_q),
    .sat_out (sat_val)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = mix_valid_q;
    chan_ack    = '0;
    underrun    = 1'b0;
    busy        = (state_q != S_IDLE);
    // A tick can only start a frame from idle; anywhere else it is dropped.
    overrun     = sample_tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (sample_tick) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (chan_enable[idx_q]) begin
          if (chan_valid[idx_q]) begin
            acc_d           = acc_q + cur_sext;
            chan_ack[idx_q] = 1'b1;
          end else begin
            underrun = 1'b1;
          end
        end
        if (last_ch) begin
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SCALE: begin
        mix_out_d   = sat_val;
        mix_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (mix_ready) begin
          mix_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// Bench for mix_scheduler: directed frames with literal expectations plus a
// randomized run, all checked every cycle against a frame-timeline model.
module tb_mix_scheduler;

  localparam int NCH = 8;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_tick;
  logic [NCH-1:0]    chan_enable;
  logic [NCH-1:0]    chan_valid;
  logic [NCH*DW-1:0] chan_data;
  logic [NCH-1:0]    chan_ack, chan_ack_s0;
  logic [DW-1:0]     mix_out, mix_out_s0;
  logic              mix_valid, mix_valid_s0;
  logic              mix_ready;
  logic              busy, busy_s0;
  logic              overrun, overrun_s0;
  logic              underrun, underrun_s0;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  mix_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .GAIN_SHIFT(3)) dut (
    .CLOCK_50(clk), .reset(reset), .sample_tick(sample_tick),
    .chan_enable(chan_enable), .chan_valid(chan_valid), .chan_data(chan_data),
    .chan_ack(chan_ack), .mix_out(mix_out), .mix_valid(mix_valid),
    .mix_ready(mix_ready), .busy(busy), .overrun(overrun), .underrun(underrun)
  );

  // Unity-gain copy on the same stimulus, so the clamp is actually reachable.
  mix_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .GAIN_SHIFT(0)) dut_s0 (
    .CLOCK_50(clk), .reset(reset), .sample_tick(sample_tick),
    .chan_enable(chan_enable), .chan_valid(chan_valid), .chan_data(chan_data),
    .chan_ack(chan_ack_s0), .mix_out(mix_out_s0), .mix_valid(mix_valid_s0),
    .mix_ready(mix_ready), .busy(busy_s0), .overrun(overrun_s0), .underrun(underrun_s0)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks_total++;
    if (act == exp) checks_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Frame-timeline model: k counts cycles since the accepted tick.
  initial begin : model
    bit busy_m, valid_m;
    int k, sum, out3_m, out0_m, c;
    logic [NCH-1:0] exp_ack;
    bit exp_und, exp_ovr;
    busy_m = 0; valid_m = 0; k = 0; sum = 0; out3_m = 0; out0_m = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_m = 0; valid_m = 0; k = 0; sum = 0; out3_m = 0; out0_m = 0;
      end
      exp_ack = '0; exp_und = 0;
      if (!reset && busy_m && k >= 1 && k <= NCH) begin
        c = k - 1;
        if (chan_enable[c]) begin
          if (chan_valid[c]) exp_ack[c] = 1'b1;
          else exp_und = 1;
        end
      end
      exp_ovr = !reset && sample_tick && busy_m;
      chk("m_ack",       chan_ack,            exp_ack);
      chk("m_ack_s0",    chan_ack_s0,         exp_ack);
      chk("m_underrun",  underrun,            exp_und);
      chk("m_overrun",   overrun,             exp_ovr);
      chk("m_busy",      busy,                busy_m);
      chk("m_valid",     mix_valid,           valid_m);
      chk("m_valid_s0",  mix_valid_s0,        valid_m);
      chk("m_out",       $signed(mix_out),    out3_m);
      chk("m_out_s0",    $signed(mix_out_s0), out0_m);
      if (!reset) begin
        if (!busy_m) begin
          if (sample_tick) begin busy_m = 1; k = 1; sum = 0; end
        end else if (k <= NCH) begin
          c = k - 1;
          if (chan_enable[c] && chan_valid[c]) sum += $signed(chan_data[c*DW +: DW]);
          k++;
        end else if (k == NCH + 1) begin
          out3_m = sat16(sum >>> 3);
          out0_m = sat16(sum);
          valid_m = 1; k++;
        end else if (mix_ready) begin
          valid_m = 0; busy_m = 0; k = 0;
        end
      end
    end
  end

  task automatic set_all(input int v);
    for (int i = 0; i < NCH; i++) chan_data[i*DW +: DW] = DW'(v);
  endtask

  int r_lat, r_acks, r_unds, r_und_cyc, r_ovr, r_xfer, r_ack_bad, r_unstable;
  int r_out3, r_out0;

  task automatic run_frame(input int rdy_dly, input int tick2);
    int n;
    r_lat = -1; r_acks = 0; r_unds = 0; r_und_cyc = -1; r_ovr = 0;
    r_xfer = -1; r_ack_bad = 0; r_unstable = 0; r_out3 = 0; r_out0 = 0;
    @(posedge clk); #1;
    sample_tick = 1; mix_ready = (rdy_dly == 0);
    n = 0;
    while (r_xfer < 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      sample_tick = (n == tick2);
      mix_ready = (n >= rdy_dly);
      #1;
      r_acks += $countones(chan_ack);
      if (chan_ack != 0 && chan_ack != (NCH'(1) << (n - 1))) r_ack_bad++;
      if (underrun) begin r_unds++; r_und_cyc = n; end
      r_ovr += int'(overrun);
      if (mix_valid && r_lat < 0) begin
        r_lat = n; r_out3 = $signed(mix_out); r_out0 = $signed(mix_out_s0);
      end
      if (mix_valid && $signed(mix_out) != r_out3) r_unstable++;
      if (mix_valid && mix_ready) r_xfer = n;
    end
    if (r_xfer < 0) begin
      checks_total++;
      $display("FAIL frame_timeout: got no transfer within %0d cycles, expected one", n);
    end
    sample_tick = 0;
    @(posedge clk); #2;
    chk("post_xfer_valid", mix_valid, 0);
    chk("post_xfer_busy",  busy,      0);
  endtask

  initial begin
    reset = 1; sample_tick = 0; chan_enable = '0; chan_valid = '0;
    chan_data = '0; mix_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out",   mix_out,   0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_busy",  busy,      0);
    chk("rst_ack",   chan_ack,  0);
    reset = 0;
    repeat (2) @(posedge clk);

    // All channels at 1000, ready already high.
    chan_enable = '1; chan_valid = '1; set_all(1000);
    run_frame(0, -1);
    chk("a_latency",   r_lat,     10);
    chk("a_out",       r_out3,    1000);
    chk("a_out_s0",    r_out0,    8000);
    chk("a_acks",      r_acks,    8);
    chk("a_ack_order", r_ack_bad, 0);
    chk("a_underrun",  r_unds,    0);

    // Saturation at unity gain, both rails.
    set_all(20000);
    run_frame(0, -1);
    chk("b_pos_out",    r_out3, 20000);
    chk("b_pos_out_s0", r_out0, 32767);
    chk("b_pos_flags",  r_unds + r_ovr, 0);
    set_all(-20000);
    run_frame(0, -1);
    chk("b_neg_out",    r_out3, -20000);
    chk("b_neg_out_s0", r_out0, -32768);

    // Only ch0 and ch2 enabled; the rest valid but must be ignored.
    set_all(9999);
    chan_enable = 8'b0000_0101;
    chan_data[0*DW +: DW] = 16'sd8000;
    chan_data[2*DW +: DW] = -16'sd16000;
    run_frame(0, -1);
    chk("c_out",       r_out3,    -1000);
    chk("c_out_s0",    r_out0,    -8000);
    chk("c_acks",      r_acks,    2);
    chk("c_ack_order", r_ack_bad, 0);
    chk("c_underrun",  r_unds,    0);

    // ch5 enabled but not valid.
    chan_enable = '1; set_all(800); chan_valid = 8'b1101_1111;
    run_frame(0, -1);
    chk("d_out",      r_out3,    700);
    chk("d_out_s0",   r_out0,    5600);
    chk("d_unds",     r_unds,    1);
    chk("d_und_cyc",  r_und_cyc, 6);
    chk("d_acks",     r_acks,    7);

    // Backpressure with a dropped tick during OUTPUT.
    chan_valid = '1; set_all(1000);
    run_frame(20, 15);
    chk("e_latency",  r_lat,      10);
    chk("e_out",      r_out3,     1000);
    chk("e_overrun",  r_ovr,      1);
    chk("e_xfer_cyc", r_xfer,     20);
    chk("e_stable",   r_unstable, 0);

    // Reset in the middle of SCAN.
    begin
      int acks_in_rst;
      set_all(500);
      @(posedge clk); #1; sample_tick = 1;
      repeat (4) begin @(posedge clk); #1; sample_tick = 0; end
      reset = 1; #1;
      chk("f_out",   mix_out,  0);
      chk("f_ack",   chan_ack, 0);
      chk("f_busy",  busy,     0);
      acks_in_rst = 0;
      repeat (2) begin @(posedge clk); #2; acks_in_rst += $countones(chan_ack); end
      chk("f_acks_in_rst", acks_in_rst, 0);
      #3; reset = 0;
      set_all(1000);
      run_frame(0, -1);
      chk("f_next_out",  r_out3, 1000);
      chk("f_next_acks", r_acks, 8);
    end

    // Every enabled channel starved.
    chan_valid = '0;
    run_frame(0, -1);
    chk("g_out",  r_out3, 0);
    chk("g_unds", r_unds, 8);
    chk("g_acks", r_acks, 0);

    // Randomized traffic; the per-cycle model does the checking.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      chan_enable = NCH'($urandom);
      chan_valid  = NCH'($urandom) | NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        case ($urandom_range(0, 3))
          0: chan_data[i*DW +: DW] = 16'h7fff;
          1: chan_data[i*DW +: DW] = 16'h8000;
          default: chan_data[i*DW +: DW] = DW'($urandom);
        endcase
      end
      sample_tick = ($urandom_range(0, 9) == 0);
      mix_ready   = ($urandom_range(0, 2) != 0);
      reset       = ($urandom_range(0, 599) == 0);
    end
    @(posedge clk); #1;
    reset = 0; sample_tick = 0; mix_ready = 1;
    repeat (30) @(posedge clk);
    #2;
    chk("end_idle", busy, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mix_scheduler.md
Name: mix_scheduler

Overview:
- Time-multiplexed mix controller for 8 voice generators: shares one accumulator across all channels, sequenced per audio sample period.
- On each sample_tick, scans channels 0..NUM_CH-1 in fixed order, pulls one sample per enabled channel via valid/ack, and accumulates.
- Scales and saturates the sum, then hands a 16-bit signed frame to the codec writer over a valid/ready handshake.
- Sits between voice generators and the audio output path; replaces the fixed adder tree where channel gating and flow control are needed.

Parameters:
- NUM_CH, 8, number of voice channels (power of 2, 2..16).
- DATA_W, 16, signed sample width, in and out.
- GAIN_SHIFT, 3, arithmetic right shift applied to the sum before saturation.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe marking the start of a sample period.
- chan_enable  in  NUM_CH  per-channel mix enable; sampled during SCAN.
- chan_valid  in  NUM_CH  channel has a sample ready.
- chan_data  in  NUM_CH*DATA_W  flattened samples; channel i at [i*DATA_W +: DATA_W].
- chan_ack  out  NUM_CH  one-cycle pulse: channel's sample consumed.
- mix_out  out  DATA_W  scaled, saturated mix; held stable while mix_valid is high.
- mix_valid  out  1  frame available.
- mix_ready  in  1  downstream accepts the frame.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  one-cycle pulse: sample_tick arrived while busy; that tick is dropped.
- underrun  out  1  one-cycle pulse: an enabled channel was not valid when scanned.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; accumulator and channel index clear to 0.
  - Outputs: mix_out=0, mix_valid=0, chan_ack=0, busy=0, overrun=0, underrun=0.
- Accumulator width: ACC_W = DATA_W + clog2(NUM_CH), which is 19 at the defaults. Channel samples are sign-extended into it.
- FSM states: IDLE, SCAN, SCALE, OUTPUT.
- IDLE:
  - On sample_tick: clear the accumulator, set idx=0, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN (one channel per cycle):
  - Enabled and valid: acc += sext(data[idx]); chan_ack[idx]=1 for that cycle.
  - Enabled and not valid: contributes 0, no ack; underrun pulses that cycle.
  - Disabled: contributes 0, no ack, no underrun; chan_valid is ignored.
  - idx==NUM_CH-1: go to SCALE; otherwise idx++.
- SCALE (one cycle):
  - s = acc >>> GAIN_SHIFT.
  - Saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and register the result into mix_out.
  - Set mix_valid=1 and go to OUTPUT.
- OUTPUT:
  - Hold mix_out and mix_valid until mix_ready=1 is seen on a rising edge.
  - On that edge: mix_valid=0 and go to IDLE. mix_out keeps its last value.
- Latency with tick at cycle 0:
  - SCAN occupies cycles 1..NUM_CH.
  - SCALE is cycle NUM_CH+1.
  - mix_valid is first high in cycle NUM_CH+2 (cycle 10 at the defaults).
  - If mix_ready is already high, the frame transfers in that cycle.
- Simultaneous events:
  - sample_tick in any non-IDLE state, including the cycle OUTPUT completes: overrun pulses, the tick is ignored, and the current frame is unaffected.
  - A new frame needs a tick while in IDLE.
- chan_ack is asserted at most once per channel per frame, and never for a disabled channel.
- Reset mid-SCAN or mid-OUTPUT: the partial frame is discarded with no output and no further acks; the next tick after reset release starts a clean frame.
- All enabled channels invalid: the frame still completes with mix_out=0.

Decomposition:
- Shared package/include (mix_defs):
  - DATA_W, NUM_CH defaults.
  - State encodings: IDLE=2'd0, SCAN=2'd1, SCALE=2'd2, OUTPUT=2'd3.
  - Saturation limits SAT_MAX and SAT_MIN.
- Sub-module: sat_shift (combinational). Takes the ACC_W signed input, applies GAIN_SHIFT, clamps to DATA_W. Reused by the existing mixer output stage.

Test Plan:
- All 8 enabled and valid at 1000, GAIN_SHIFT=3, mix_ready=1: mix_out=1000 with mix_valid at tick+10; chan_ack pulses on ch0..ch7 in cycles 1..8.
- GAIN_SHIFT=0, all channels at 20000: mix_out=32767. All at -20000: mix_out=-32768. No overrun or underrun.
- chan_enable=8'b0000_0101, ch0=8000, ch2=-16000, others valid at 9999, shift 3: mix_out=-1000; chan_ack only on ch0 and ch2.
- ch5 enabled but invalid, others at 800, shift 3: underrun pulses in cycle 6; no ack on ch5; mix_out=700.
- mix_ready held low 20 cycles, tick at tick+15: mix_valid and mix_out stay stable, overrun pulses once, and exactly one frame transfers when ready rises.
- reset asserted at tick+4, released 2 cycles later: outputs go to 0 immediately with no further acks; the next tick yields a correct, complete frame.
